// File: rtl/ksa_pkg.sv
// Shared definitions for the chunked Kogge-Stone adder: FSM states and
// default geometry (16-bit chunks, four chunks).
package ksa_pkg;

  localparam int KSA_N = 16;
  localparam int KSA_K = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : ksa_pkg

// File: rtl/ksa.sv
// Combinational N-bit Kogge-Stone adder with carry-in.
// The carry-in is folded into the bit-0 generate term. A log2(N)-level
// parallel prefix then gives the carry into every bit position.
module ksa #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int L = $clog2(N);

  logic [N-1:0] hp_s;
  logic [N-1:0] c_s;
  logic [N-1:0] g_s [0:L];
  logic [N-1:0] p_s [0:L];

  // Prefix tree: group generate/propagate per level, then sum and carry out
  always_comb begin
    hp_s   = a ^ b;
    g_s[0] = a & b;
    p_s[0] = hp_s;
    g_s[0][0] = (a[0] & b[0]) | (hp_s[0] & cin);
    for (int lvl = 1; lvl <= L; lvl++) begin
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << (lvl - 1))) begin
          g_s[lvl][i] = g_s[lvl-1][i] | (p_s[lvl-1][i] & g_s[lvl-1][i-(1 << (lvl - 1))]);
          p_s[lvl][i] = p_s[lvl-1][i] & p_s[lvl-1][i-(1 << (lvl - 1))];
        end else begin
          g_s[lvl][i] = g_s[lvl-1][i];
          p_s[lvl][i] = p_s[lvl-1][i];
        end
      end
    end
    c_s[0] = cin;
    for (int i = 1; i < N; i++) begin
      c_s[i] = g_s[L][i-1];
    end
    s    = hp_s ^ c_s;
    cout = g_s[L][N-1];
  end

endmodule : ksa

// File: rtl/ksa_chunk_adder.sv
// W = N*K bit adder that reuses a single N-bit Kogge-Stone instance over K cycles.
// The lowest chunk is added first. The carry register links consecutive chunks.
// The result is held in DONE until the consumer accepts it.
module ksa_chunk_adder
  import ksa_pkg::*;
#(
  parameter int N = KSA_N,
  parameter int K = KSA_K
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   in_a,
  input  logic [N*K-1:0]   in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_r;
  logic            carry_r, carry_s;
  logic [W-1:0]    a_r, b_r, sum_r, sum_s;
  logic            accept_s, last_s;

  logic [N-1:0]    ksa_a_s, ksa_b_s, ksa_sum_s;
  logic            ksa_cin_s, ksa_cout_s;

  logic            in_ready_r, out_valid_r, busy_r, out_cout_r, out_ovf_r;
  logic [W-1:0]    out_sum_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;

  assign accept_s = in_valid && (state_r == IDLE);
  assign last_s   = (idx_r == IW'(K - 1));

  // Feed the current chunk to the adder in RUN; hold its inputs at zero otherwise
  always_comb begin
    if (state_r == RUN) begin
      ksa_a_s   = a_r[idx_r*N +: N];
      ksa_b_s   = b_r[idx_r*N +: N];
      ksa_cin_s = carry_r;
    end else begin
      ksa_a_s   = {N{1'b0}};
      ksa_b_s   = {N{1'b0}};
      ksa_cin_s = 1'b0;
    end
  end

  ksa #(.N(N)) u_ksa (
    .a    (ksa_a_s),
    .b    (ksa_b_s),
    .cin  (ksa_cin_s),
    .s    (ksa_sum_s),
    .cout (ksa_cout_s)
  );

  // Next-state, next partial sum and next carry
  always_comb begin
    state_s = state_r;
    sum_s   = sum_r;
    carry_s = carry_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
          carry_s = in_cin;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        sum_s[idx_r*N +: N] = ksa_sum_s;
        carry_s             = ksa_cout_s;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand latch, chunk index, carry and partial-sum registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      carry_r <= carry_s;
      if (accept_s) begin
        a_r   <= in_a;
        b_r   <= in_b;
        idx_r <= {IW{1'b0}};
        sum_r <= {W{1'b0}};
      end else if (state_r == RUN) begin
        sum_r <= sum_s;
        idx_r <= last_s ? idx_r : idx_r + {{(IW-1){1'b0}}, 1'b1};
      end else begin
        sum_r <= sum_r;
        idx_r <= idx_r;
      end
    end
  end

  // Registered handshake and result outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= {W{1'b0}};
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      out_valid_r <= (state_s == DONE);
      if (state_s == DONE) begin
        out_sum_r  <= sum_s;
        out_cout_r <= carry_s;
        out_ovf_r  <= (a_r[W-1] == b_r[W-1]) && (sum_s[W-1] != a_r[W-1]);
      end else begin
        out_sum_r  <= {W{1'b0}};
        out_cout_r <= 1'b0;
        out_ovf_r  <= 1'b0;
      end
    end
  end

endmodule : ksa_chunk_adder

// File: tb/tb_ksa_chunk_adder.sv
// Self-checking bench for ksa_chunk_adder at N=16, K=4.
// Directed vectors come from a table. Hand-written sequences cover
// backpressure and reset-abort. Random operands with random stalls are
// checked against a 65-bit arithmetic reference.
module tb_ksa_chunk_adder;

  localparam int N = 16;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ksa_chunk_adder #(.N(N), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Present one operand set. Returns after the accept edge.
  // Afterwards the input bus carries junk, to prove the operands were latched.
  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic cin);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    in_cin   = 1'($urandom);
  endtask

  // Count cycles from the accept edge until out_valid. The wait is bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Reference model: plain 65-bit addition plus the sign rule for overflow.
  task automatic ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         output logic [63:0] s, output logic c, output logic o);
    logic [64:0] full;
    full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    s    = full[63:0];
    c    = full[64];
    o    = (a[63] == b[63]) && (s[63] != a[63]);
  endtask

  initial begin
    int          lat;
    logic [63:0] ra, rb, rs, held;
    logic        rc, rcout, rovf;
    int          stall;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = {$urandom, $urandom};
    in_b      = {$urandom, $urandom};
    in_cin    = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();

    // State immediately after reset
    check("reset_in_ready",  {63'd0, in_ready},  64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_busy",      {63'd0, busy},      64'd0);
    check("reset_out_sum",   out_sum,            64'd0);
    check("reset_out_cout",  {63'd0, out_cout},  64'd0);
    check("reset_out_ovf",   {63'd0, out_ovf},   64'd0);
    reset = 1'b1;
    tick();
    // Garbage on the operand bus without in_valid must be ignored
    check("idle_ignore_in_ready", {63'd0, in_ready}, 64'd1);
    check("idle_ignore_busy",     {63'd0, busy},     64'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin);
      check("vec_busy_after_accept", {63'd0, busy}, 64'd1);
      check("vec_out_sum_zero_in_run", out_sum, 64'd0);
      wait_result(lat);
      check("vec_latency", 64'(lat), 64'd4);
      check("vec_sum",  out_sum,            vecs[i].sum);
      check("vec_cout", {63'd0, out_cout},  {63'd0, vecs[i].cout});
      check("vec_ovf",  {63'd0, out_ovf},   {63'd0, vecs[i].ovf});
      handshake();
      check("vec_in_ready_after_hs",  {63'd0, in_ready},  64'd1);
      check("vec_out_valid_after_hs", {63'd0, out_valid}, 64'd0);
      check("vec_out_sum_after_hs",   out_sum,            64'd0);
    end

    // Backpressure: result held for 5 stalled cycles
    accept(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'd4);
    held = out_sum;
    check("bp_sum", held, 64'h1234_5678_9ABC_DF00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum_stable", out_sum, 64'h1234_5678_9ABC_DF00);
      check("bp_valid_held", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    handshake();
    check("bp_in_ready_after_hs", {63'd0, in_ready}, 64'd1);

    // Reset two cycles after accept aborts the add
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_abort_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_abort_busy",      {63'd0, busy},      64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_abort_no_result", {63'd0, out_valid}, 64'd0);
    end
    accept(64'd3, 64'd5, 1'b0);
    wait_result(lat);
    check("rst_then_latency", 64'(lat), 64'd4);
    check("rst_then_sum", out_sum, 64'd8);
    handshake();

    // Random operands with random consumer stalls and idle gaps
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (i % 8 == 0) ra[15:0] = 16'hFFFF;
      ref_add(ra, rb, rc, rs, rcout, rovf);
      accept(ra, rb, rc);
      wait_result(lat);
      check("rnd_latency", 64'(lat), 64'd4);
      check("rnd_sum",  out_sum,           rs);
      check("rnd_cout", {63'd0, out_cout}, {63'd0, rcout});
      check("rnd_ovf",  {63'd0, out_ovf},  {63'd0, rovf});
      stall = $urandom_range(0, 3);
      for (int j = 0; j < stall; j++) begin
        tick();
        check("rnd_stall_sum", out_sum, rs);
      end
      handshake();
      check("rnd_out_valid_after_hs", {63'd0, out_valid}, 64'd0);
      stall = $urandom_range(0, 2);
      for (int j = 0; j < stall; j++) begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ksa_chunk_adder

// File: doc/ksa_chunk_adder.md
KSA_CHUNK_ADDER -- requirements
Module: ksa_chunk_adder

Interface
REQ-001 Parameter N, default 16: chunk width; this is also the width of the ksa instance.
REQ-002 Parameter K, default 4: chunk count; operand width W = N*K; K >= 1.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operands present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_cin  input  1  carry-in.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  W  sum, in_a + in_b + in_cin mod 2^W.
REQ-013 out_cout  output  1  carry out of bit W-1.
REQ-014 out_ovf  output  1  two's-complement overflow.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; it is a registered decode of the state with no combinational path from in_valid.
REQ-018 Accept occurs on an edge with in_valid && in_ready: latch in_a, in_b and in_cin; clear chunk index idx to 0; set carry register to in_cin; go to RUN.
REQ-019 While in IDLE, in_a, in_b and in_cin are ignored unless in_valid is 1.
REQ-020 Each RUN cycle SHALL drive the ksa instance with a_reg[idx*N +: N], b_reg[idx*N +: N] and the carry register.
REQ-021 On each RUN edge: sum_reg[idx*N +: N] <= ksa.s; carry <= ksa.cout; idx <= idx+1.
REQ-022 When idx == K-1 at the edge, the next state SHALL be DONE, not a further RUN.
REQ-023 Latency: out_valid SHALL rise exactly K cycles after the accept edge.
REQ-024 For K=1, the result SHALL appear 1 cycle after accept.
REQ-025 In DONE: out_valid=1; out_sum=sum_reg; out_cout=carry; out_ovf=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
REQ-026 out_sum, out_cout and out_ovf SHALL hold stable while out_valid && !out_ready, for any number of cycles.
REQ-027 On an edge with out_valid && out_ready, the next state SHALL be IDLE.
REQ-028 Minimum spacing between consecutive accepts is K+2 cycles.
REQ-029 Outside DONE: out_valid=0, and out_sum, out_cout and out_ovf SHALL read 0.
REQ-030 The idx counter width SHALL be $clog2(K) bits, minimum 1.
REQ-031 idx never exceeds K-1; no wrap-around is visible.
REQ-032 Unused ksa inputs outside RUN SHALL be driven 0 to avoid X propagation.

Reset
REQ-033 reset=0 at an edge SHALL force: state IDLE; idx 0; carry 0; a_reg, b_reg and sum_reg 0.
REQ-034 Resulting outputs after reset: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0.
REQ-035 Reset asserted in RUN or DONE SHALL abort the operation with no result emitted.
REQ-036 Reset SHALL take priority over a simultaneous accept or output handshake.

Structure
REQ-037 Package ksa_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and default constants KSA_N=16 and KSA_K=4.
REQ-038 Exactly one sub-module SHALL be used: the existing combinational ksa, instantiated with .N(N).
REQ-039 No other carry logic SHALL exist; all chunk arithmetic goes through ksa.

Verification
All scenarios use N=16, K=4, W=64.
REQ-040 Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum 0x0, cout 1, ovf 0; out_valid exactly 4 cycles after accept.
REQ-041 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum 0x8000_0000_0000_0000, cout 0, ovf 1.
REQ-042 Chunk carry and cin: a=0x0000_0000_0000_FFFF, b=0x0, cin=1 -> sum 0x0000_0000_0001_0000, cout 0, ovf 0.
REQ-043 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum stable and in_ready=0 throughout; handshake then in_ready=1 next cycle.
REQ-044 Reset mid-RUN: assert reset 2 cycles after accept -> next cycle out_valid=0, in_ready=1; then a new add of 3+5 yields 8.
REQ-045 Random: 1000 random a, b, cin with random out_ready stalls -> every result matches a+b+cin using a 65-bit reference; zero errors reported.
